// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write side: operand address, data width and the
// writeback request carried through the mul/div result buffer.
package wb_port_arbiter_pkg;
  localparam int DATA_32_W       = 32;
  localparam int REG_ADDR_W      = 4;
  localparam int WB_STARVE_LIMIT = 4;

  typedef logic [REG_ADDR_W-1:0] t_instr_register;

  typedef struct packed {
    t_instr_register        addr;
    logic [DATA_32_W-1:0]   data;
  } t_wb_req;
endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of writeback requests; power-of-two depth so pointers wrap for free.
module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  t_wb_req push_req,
  output t_wb_req head,
  output logic    full,
  output logic    empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  t_wb_req          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage carries data only; occupancy is tracked by the reset control above.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_req;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/wb_port_arbiter.sv
// Owns the register-file write port: pipeline writebacks win, buffered mul/div results drain
// in gaps or by forcing a one-cycle pipe stall; tracks registers still owed by mul/div.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_FILE_DEPTH = 16,
  parameter int MD_FIFO_DEPTH  = 2,
  parameter int STARVE_LIMIT   = WB_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_wr_en,
  input  t_instr_register      pipe_wr_addr,
  input  logic [DATA_32_W-1:0] pipe_wr_data,
  output logic                 pipe_stall,
  input  logic                 md_issue_valid,
  input  t_instr_register      md_issue_addr,
  input  logic                 md_res_valid,
  output logic                 md_res_ready,
  input  t_instr_register      md_res_addr,
  input  logic [DATA_32_W-1:0] md_res_data,
  input  t_instr_register      dec_rs1_addr,
  input  t_instr_register      dec_rs2_addr,
  input  t_instr_register      dec_rd_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rd_busy,
  output logic                 reg_file_write,
  output t_instr_register      reg_file_wr_addr,
  output logic [DATA_32_W-1:0] reg_file_wr_data
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(STARVE_LIMIT);

  t_wb_req                   head;
  t_wb_req                   push_req;
  logic                      full, empty, push, pop;
  logic                      pipe_win, head_wr;
  logic [REG_FILE_DEPTH-1:0] sb, sb_next;
  logic [CNT_W-1:0]          starve_cnt, starve_next;

  function automatic logic busy_of(input logic [REG_FILE_DEPTH-1:0] bits,
                                   input t_instr_register addr);
    return (addr != '0) && bits[addr];
  endfunction

  assign push_req = '{addr: md_res_addr, data: md_res_data};
  assign md_res_ready = !full;
  assign push = md_res_valid && !full;

  wb_result_fifo #(.DEPTH(MD_FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_req (push_req),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // A write to r0 is an idle slot, and a stall cycle always belongs to the buffered head.
  assign pipe_win = pipe_wr_en && (pipe_wr_addr != '0) && !pipe_stall;
  assign pop      = !empty && !pipe_win;
  assign head_wr  = pop && (head.addr != '0);

  always_comb begin
    starve_next = starve_cnt;
    if (empty || pop)
      starve_next = '0;
    else if (starve_cnt != LIMIT_CNT)
      starve_next = starve_cnt + CNT_W'(1);
  end

  // Clear is applied before set so a re-issue in the retiring cycle keeps the register pending.
  always_comb begin
    sb_next = sb;
    if (head_wr)
      sb_next[head.addr] = 1'b0;
    if (md_issue_valid && (md_issue_addr != '0))
      sb_next[md_issue_addr] = 1'b1;
  end

  assign rs1_busy = busy_of(sb, dec_rs1_addr);
  assign rs2_busy = busy_of(sb, dec_rs2_addr);
  assign rd_busy  = busy_of(sb, dec_rd_addr);

  // Registered write port and bookkeeping state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_file_write   <= 1'b0;
      reg_file_wr_addr <= '0;
      reg_file_wr_data <= '0;
      pipe_stall       <= 1'b0;
      starve_cnt       <= '0;
      sb               <= '0;
    end else begin
      reg_file_write <= pipe_win || head_wr;
      if (pipe_win) begin
        reg_file_wr_addr <= pipe_wr_addr;
        reg_file_wr_data <= pipe_wr_data;
      end else if (head_wr) begin
        reg_file_wr_addr <= head.addr;
        reg_file_wr_data <= head.data;
      end
      pipe_stall <= (starve_next == LIMIT_CNT);
      starve_cnt <= starve_next;
      sb         <= sb_next;
    end
  end

  a_no_write_in_stall: assert property (@(posedge clk) disable iff (rst)
    !(pipe_wr_en && pipe_stall));

  a_no_write_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(pipe_wr_en && busy_of(sb, pipe_wr_addr)));
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected writes queued at stimulus time, a negedge
// monitor pops and compares every reg_file write; control flags checked inline.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 pipe_wr_en = 1'b0;
  t_instr_register      pipe_wr_addr = '0;
  logic [DATA_32_W-1:0] pipe_wr_data = '0;
  logic                 pipe_stall;
  logic                 md_issue_valid = 1'b0;
  t_instr_register      md_issue_addr = '0;
  logic                 md_res_valid = 1'b0;
  logic                 md_res_ready;
  t_instr_register      md_res_addr = '0;
  logic [DATA_32_W-1:0] md_res_data = '0;
  t_instr_register      dec_rs1_addr = '0;
  t_instr_register      dec_rs2_addr = '0;
  t_instr_register      dec_rd_addr = '0;
  logic                 rs1_busy, rs2_busy, rd_busy;
  logic                 reg_file_write;
  t_instr_register      reg_file_wr_addr;
  logic [DATA_32_W-1:0] reg_file_wr_data;

  int      errors = 0;
  int      checks = 0;
  t_wb_req exp_q[$];
  t_wb_req mon_exp;

  wb_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .pipe_wr_en       (pipe_wr_en),
    .pipe_wr_addr     (pipe_wr_addr),
    .pipe_wr_data     (pipe_wr_data),
    .pipe_stall       (pipe_stall),
    .md_issue_valid   (md_issue_valid),
    .md_issue_addr    (md_issue_addr),
    .md_res_valid     (md_res_valid),
    .md_res_ready     (md_res_ready),
    .md_res_addr      (md_res_addr),
    .md_res_data      (md_res_data),
    .dec_rs1_addr     (dec_rs1_addr),
    .dec_rs2_addr     (dec_rs2_addr),
    .dec_rd_addr      (dec_rd_addr),
    .rs1_busy         (rs1_busy),
    .rs2_busy         (rs2_busy),
    .rd_busy          (rd_busy),
    .reg_file_write   (reg_file_write),
    .reg_file_wr_addr (reg_file_wr_addr),
    .reg_file_wr_data (reg_file_wr_data)
  );

  always #5 clk = ~clk;

  function automatic t_wb_req mk(input int addr, input logic [31:0] data);
    t_wb_req r;
    r.addr = t_instr_register'(addr);
    r.data = data;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && reg_file_write) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write",
                 reg_file_wr_addr, reg_file_wr_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_file_wr_addr !== mon_exp.addr || reg_file_wr_data !== mon_exp.data) begin
          errors++;
          $display("FAIL wr_port: got addr=%0d data=%h, required addr=%0d data=%h",
                   reg_file_wr_addr, reg_file_wr_data, mon_exp.addr, mon_exp.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wr_en     = 1'b0;
    pipe_wr_addr   = '0;
    pipe_wr_data   = '0;
    md_issue_valid = 1'b0;
    md_issue_addr  = '0;
    md_res_valid   = 1'b0;
    md_res_addr    = '0;
    md_res_data    = '0;
  endtask

  task automatic pipe_write(input int addr, input logic [31:0] data);
    pipe_wr_en   = 1'b1;
    pipe_wr_addr = t_instr_register'(addr);
    pipe_wr_data = data;
    exp_q.push_back(mk(addr, data));
  endtask

  task automatic md_result(input int addr, input logic [31:0] data);
    md_res_valid = 1'b1;
    md_res_addr  = t_instr_register'(addr);
    md_res_data  = data;
  endtask

  task automatic md_issue(input int addr);
    md_issue_valid = 1'b1;
    md_issue_addr  = t_instr_register'(addr);
  endtask

  bit stall_exp [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  bit ready_exp [11] = '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    // Reset values, both held and just after release.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_write", reg_file_write, 0);
    chk("rst_addr", reg_file_wr_addr, 0);
    chk("rst_data", reg_file_wr_data, 0);
    rst = 1'b0;
    chk("rst_stall", pipe_stall, 0);
    chk("rst_ready", md_res_ready, 1);
    tick();
    chk("post_rst_write", reg_file_write, 0);

    // Plain pipeline write, one-cycle latency.
    pipe_write(3, 32'hDEADBEEF);
    tick();
    idle_inputs();
    chk("pipe_wr_latency", reg_file_write, 1);
    chk("pipe_wr_addr", reg_file_wr_addr, 3);
    tick();
    chk("pipe_wr_single", reg_file_write, 0);

    // Issue r5: no same-cycle bypass, then busy until its result is written.
    md_issue(5);
    dec_rs1_addr = 5;
    dec_rs2_addr = 5;
    #1;
    chk("rs1_no_bypass", rs1_busy, 0);
    tick();
    idle_inputs();
    chk("rs1_busy_r5", rs1_busy, 1);
    chk("rs2_busy_r5", rs2_busy, 1);
    md_result(5, 32'h12);
    exp_q.push_back(mk(5, 32'h12));
    tick();
    idle_inputs();
    chk("rs1_busy_buffered", rs1_busy, 1);
    tick();
    chk("md_wr_r5", reg_file_write, 1);
    chk("rs1_busy_cleared", rs1_busy, 0);
    dec_rs1_addr = '0;
    dec_rs2_addr = '0;

    // Two buffered results starved by back-to-back pipe writes.
    for (int k = 0; k < 11; k++) begin
      idle_inputs();
      if (k == 0) md_result(9, 32'hA1);
      if (k == 1) md_result(10, 32'hA2);
      if (k == 5) exp_q.push_back(mk(9, 32'hA1));
      else if (k == 10) exp_q.push_back(mk(10, 32'hA2));
      else pipe_write(1 + (k % 6), 32'h100 + k);
      tick();
      chk($sformatf("starve_stall_k%0d", k), pipe_stall, stall_exp[k]);
      chk($sformatf("starve_ready_k%0d", k), md_res_ready, ready_exp[k]);
    end
    idle_inputs();
    tick();

    // Re-issue of r7 in the cycle its result retires keeps it pending.
    dec_rd_addr = 7;
    md_issue(7);
    tick();
    idle_inputs();
    md_result(7, 32'h77);
    tick();
    idle_inputs();
    md_issue(7);
    exp_q.push_back(mk(7, 32'h77));
    tick();
    idle_inputs();
    chk("rd_busy_set_wins", rd_busy, 1);
    md_result(7, 32'h78);
    exp_q.push_back(mk(7, 32'h78));
    tick();
    idle_inputs();
    tick();
    chk("rd_busy_r7_cleared", rd_busy, 0);

    // r0: pipe write to r0 lets the FIFO drain; r0 result is consumed silently; r0 never busy.
    md_result(6, 32'h66);
    tick();
    idle_inputs();
    pipe_wr_en   = 1'b1;
    pipe_wr_addr = '0;
    pipe_wr_data = 32'hCAFE0000;
    exp_q.push_back(mk(6, 32'h66));
    tick();
    idle_inputs();
    chk("r0_pipe_drain_addr", reg_file_wr_addr, 6);
    md_result(0, 32'h55);
    md_issue(0);
    dec_rd_addr = 0;
    tick();
    idle_inputs();
    chk("r0_never_busy", rd_busy, 0);
    tick();
    chk("r0_result_no_write", reg_file_write, 0);
    chk("r0_result_ready", md_res_ready, 1);

    // Reset with two buffered results and r4 pending.
    dec_rd_addr = 4;
    md_issue(4);
    pipe_write(1, 32'h201);
    tick();
    idle_inputs();
    md_result(11, 32'hB1);
    pipe_write(2, 32'h202);
    tick();
    idle_inputs();
    md_result(12, 32'hB2);
    pipe_write(3, 32'h203);
    tick();
    idle_inputs();
    chk("pre_rst_r4_busy", rd_busy, 1);
    chk("pre_rst_full", md_res_ready, 0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", reg_file_write, 0);
    chk("mid_rst_addr", reg_file_wr_addr, 0);
    chk("mid_rst_data", reg_file_wr_data, 0);
    chk("mid_rst_r4_busy", rd_busy, 0);
    chk("mid_rst_ready", md_res_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("post_rst_r4_busy", rd_busy, 0);
    chk("post_rst_stall", pipe_stall, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
